jvm_insn_splitter: RTL and testbench

Streaming JVM bytecode splitter that sits between the method-code fetch buffer and the translation front end. It accepts one bytecode byte per beat and forwards it one cycle later, tagged with instruction start and end markers and the method-relative PC of the owning instruction. It handles every fixed-length opcode, the `wide` prefix and, when configured, the variable-length `tableswitch` and `lookupswitch`. It flags undefined opcodes with a sticky error.

---
 rtl/jvm_pkg.sv | 54 +++++
 rtl/jvm_switch_len.sv | 50 +++++
 rtl/jvm_insn_splitter.sv | 201 ++++++++++++++++++++
 tb/tb_jvm_insn_splitter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jvm_pkg.sv
// Shared opcode constants, splitter state encoding, error codes and the
// fixed-operand length table for the JVM instruction splitter.
package jvm_pkg;

    localparam logic [7:0] OP_WIDE         = 8'hC4;
    localparam logic [7:0] OP_IINC         = 8'h84;
    localparam logic [7:0] OP_TABLESWITCH  = 8'hAA;
    localparam logic [7:0] OP_LOOKUPSWITCH = 8'hAB;

    typedef enum logic [2:0] {
        S_OPC  = 3'd0,
        S_FIX  = 3'd1,
        S_WOPC = 3'd2,
        S_PAD  = 3'd3,
        S_HDR  = 3'd4,
        S_BODY = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_UNDEF  = 2'd1;
    localparam logic [1:0] ERR_SWITCH = 2'd2;
    localparam logic [1:0] ERR_UNSUP  = 2'd3;

    typedef struct packed {
        logic       undef;
        logic [2:0] len;
    } op_len_t;

    // wide, tableswitch and lookupswitch report length 0 here; the splitter
    // intercepts them before the table result is used.
    function automatic op_len_t op_len(input logic [7:0] op);
        op_len_t r;
        r.undef = 1'b0;
        r.len   = 3'd0;
        case (op) inside
            8'h10, 8'h12, [8'h15:8'h19], [8'h36:8'h3A], 8'hA9, 8'hBC:
                r.len = 3'd1;
            8'h11, 8'h13, 8'h14, 8'h84, [8'h99:8'hA8], [8'hB2:8'hB8],
            8'hBB, 8'hBD, 8'hC0, 8'hC1, 8'hC6, 8'hC7:
                r.len = 3'd2;
            8'hC5:
                r.len = 3'd3;
            8'hB9, 8'hBA, 8'hC8, 8'hC9:
                r.len = 3'd4;
            [8'hCB:8'hFD]:
                r.undef = 1'b1;
            default:
                r.len = 3'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jvm_switch_len.sv
// Switch header collector: assembles big-endian header words and computes the
// body byte count of a tableswitch/lookupswitch, flagging bad bounds or overflow.
module jvm_switch_len
    import jvm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift,
    input  logic             latch_low,
    input  logic             is_table,
    input  logic [7:0]       din,
    output logic [CNT_W-1:0] body_len,
    output logic             bad
);

    // Only the three most recent bytes are stored; the incoming byte completes the word.
    logic [23:0] hdr;
    logic [31:0] low;
    logic [31:0] word;
    logic [33:0] span;
    logic [35:0] body;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr <= '0;
            low <= '0;
        end else begin
            if (shift)     hdr <= word[23:0];
            if (latch_low) low <= word;
        end
    end

    always_comb begin
        word = {hdr, din};
        // high - low + 1 in 34-bit two's complement cannot wrap for any 32-bit inputs
        span = {{2{word[31]}}, word} - {{2{low[31]}}, low} + 34'd1;
        if (is_table) begin
            body = {span, 2'b00};
            bad  = span[33] | (span == 34'd0);
        end else begin
            body = {1'b0, word, 3'b000};
            bad  = word[31];
        end
        bad      = bad | (|body[35:CNT_W]);
        body_len = body[CNT_W-1:0];
    end

endmodule

// File: rtl/jvm_insn_splitter.sv
// Streaming JVM bytecode splitter: tags each byte with sop/eop and owning PC.
// Switch parsing is built only when JVM_SPLIT_SWITCH_EN is defined.
module jvm_insn_splitter
    import jvm_pkg::*;
#(
    parameter int PC_W  = 16,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_start,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      in_byte,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_byte,
    output logic            out_sop,
    output logic            out_eop,
    output logic [PC_W-1:0] out_ins_pc,
    output logic            err,
    output logic [1:0]      err_code
);

    // Handshake: a byte moves when valid & ready are both high at a clock edge;
    // valid never depends on ready, and a stalled output holds every out_* field.
    state_t          st, st_n, cur;
    logic [2:0]      rem, rem_n;
    logic [PC_W-1:0] pc, pc_n, cur_pc, ins_pc_n;
    logic            run, acc, fwd_n, sop_n, eop_n, err_n;
    logic [1:0]      code_n;
    op_len_t         lk;

    assign in_ready = run & (~out_valid | out_ready);
    assign acc      = in_valid & in_ready;

`ifdef JVM_SPLIT_SWITCH_EN
    logic [3:0]       hdr_cnt, hdr_cnt_n;
    logic             is_tab, is_tab_n;
    logic [CNT_W-1:0] body_rem, body_rem_n, body_len;
    logic             sw_bad;

    jvm_switch_len #(.CNT_W(CNT_W)) u_switch_len (
        .clk       (clk),
        .rst       (rst),
        .shift     (acc && cur == S_HDR),
        .latch_low (acc && cur == S_HDR && hdr_cnt == 4'd5),
        .is_table  (is_tab),
        .din       (in_byte),
        .body_len  (body_len),
        .bad       (sw_bad)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_cnt  <= '0;
            is_tab   <= 1'b0;
            body_rem <= '0;
        end else if (acc) begin
            hdr_cnt  <= hdr_cnt_n;
            is_tab   <= is_tab_n;
            body_rem <= body_rem_n;
        end
    end
`endif

    always_comb begin
        cur      = in_start ? S_OPC : st;
        cur_pc   = in_start ? '0 : pc;
        lk       = op_len(in_byte);
        st_n     = cur;
        rem_n    = rem;
        pc_n     = cur_pc + PC_W'(1);
        ins_pc_n = out_ins_pc;
        sop_n    = 1'b0;
        eop_n    = 1'b0;
        fwd_n    = 1'b1;
        err_n    = in_start ? 1'b0 : err;
        code_n   = in_start ? ERR_NONE : err_code;
`ifdef JVM_SPLIT_SWITCH_EN
        hdr_cnt_n  = hdr_cnt;
        is_tab_n   = is_tab;
        body_rem_n = body_rem;
`endif
        case (cur)
            S_OPC: begin
                sop_n    = 1'b1;
                ins_pc_n = cur_pc;
                if (in_byte == OP_WIDE) begin
                    st_n = S_WOPC;
                end else if (in_byte == OP_TABLESWITCH || in_byte == OP_LOOKUPSWITCH) begin
`ifdef JVM_SPLIT_SWITCH_EN
                    is_tab_n  = (in_byte == OP_TABLESWITCH);
                    hdr_cnt_n = (in_byte == OP_TABLESWITCH) ? 4'd12 : 4'd8;
                    st_n      = (cur_pc[1:0] == 2'd3) ? S_HDR : S_PAD;
`else
                    st_n   = S_ERR;
                    err_n  = 1'b1;
                    code_n = ERR_UNSUP;
`endif
                end else if (lk.undef) begin
                    st_n   = S_ERR;
                    err_n  = 1'b1;
                    code_n = ERR_UNDEF;
                end else if (lk.len == 3'd0) begin
                    eop_n = 1'b1;
                end else begin
                    rem_n = lk.len;
                    st_n  = S_FIX;
                end
            end
            S_FIX: begin
                if (rem == 3'd1) begin
                    eop_n = 1'b1;
                    st_n  = S_OPC;
                end else begin
                    rem_n = rem - 3'd1;
                end
            end
            S_WOPC: begin
                if (in_byte == OP_IINC) begin
                    rem_n = 3'd4;
                    st_n  = S_FIX;
                end else if (in_byte inside {[8'h15:8'h19], [8'h36:8'h3A], 8'hA9}) begin
                    rem_n = 3'd2;
                    st_n  = S_FIX;
                end else begin
                    st_n   = S_ERR;
                    err_n  = 1'b1;
                    code_n = ERR_UNDEF;
                end
            end
`ifdef JVM_SPLIT_SWITCH_EN
            S_PAD: begin
                if (cur_pc[1:0] == 2'd3) st_n = S_HDR;
            end
            S_HDR: begin
                hdr_cnt_n = hdr_cnt - 4'd1;
                if (hdr_cnt == 4'd1) begin
                    if (sw_bad) begin
                        st_n   = S_ERR;
                        err_n  = 1'b1;
                        code_n = ERR_SWITCH;
                    end else if (body_len == '0) begin
                        eop_n = 1'b1;
                        st_n  = S_OPC;
                    end else begin
                        body_rem_n = body_len;
                        st_n       = S_BODY;
                    end
                end
            end
            S_BODY: begin
                if (body_rem == CNT_W'(1)) begin
                    eop_n = 1'b1;
                    st_n  = S_OPC;
                end else begin
                    body_rem_n = body_rem - CNT_W'(1);
                end
            end
`endif
            S_ERR: begin
                fwd_n = 1'b0;
            end
            default: begin
                st_n = S_OPC;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run        <= 1'b0;
            st         <= S_OPC;
            rem        <= '0;
            pc         <= '0;
            out_valid  <= 1'b0;
            out_byte   <= '0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
            out_ins_pc <= '0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            run <= 1'b1;
            if (in_ready) out_valid <= acc & fwd_n;
            if (acc) begin
                st         <= st_n;
                rem        <= rem_n;
                pc         <= pc_n;
                out_byte   <= in_byte;
                out_sop    <= sop_n;
                out_eop    <= eop_n;
                out_ins_pc <= ins_pc_n;
                err        <= err_n;
                err_code   <= code_n;
            end
        end
    end

endmodule

// File: tb/tb_jvm_insn_splitter.sv
// Self-checking bench for jvm_insn_splitter: instruction-level stimulus generator
// builds the byte stream and the expected tagged output; a monitor scoreboards it.
module tb_jvm_insn_splitter;
    localparam int PC_W  = 16;
    localparam int CNT_W = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_start, in_valid, in_ready;
    logic [7:0]      in_byte;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [7:0]      out_byte;
    logic            out_sop, out_eop, err;
    logic [PC_W-1:0] out_ins_pc;
    logic [1:0]      err_code;

    always #5 clk = ~clk;

    jvm_insn_splitter #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_start   (in_start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_byte    (in_byte),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_byte   (out_byte),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_ins_pc (out_ins_pc),
        .err        (err),
        .err_code   (err_code)
    );

    int n_checks = 0;
    int n_errors = 0;
    int ready_mode = 0;
    bit gaps_en = 0;
    bit need_start = 0;

    logic [8:0]  stim_q[$];
    logic [28:0] exp_q[$];
    logic [15:0] m_pc = '0;
    logic [15:0] m_ipc = '0;
    bit          m_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic int ref_len(input logic [7:0] op);
        case (op) inside
            8'h10, 8'h12, [8'h15:8'h19], [8'h36:8'h3A], 8'hA9, 8'hBC: return 1;
            8'h11, 8'h13, 8'h14, 8'h84, [8'h99:8'hA8], [8'hB2:8'hB8],
            8'hBB, 8'hBD, 8'hC0, 8'hC1, 8'hC6, 8'hC7: return 2;
            8'hC5: return 3;
            8'hB9, 8'hBA, 8'hC8, 8'hC9: return 4;
            [8'hCB:8'hFD]: return -1;
            default: return 0;
        endcase
    endfunction

    // One input byte plus what the splitter must emit for it (nothing while in error).
    task automatic emit(input logic [7:0] b, input bit st, input bit sop, input bit eop,
                        input logic [1:0] code);
        if (st) begin
            m_pc  = '0;
            m_err = 0;
        end
        if (sop) m_ipc = m_pc;
        stim_q.push_back({st, b});
        if (!m_err) exp_q.push_back({b, sop, eop, m_ipc, code != 2'd0, code});
        if (code != 2'd0) m_err = 1;
        m_pc = m_pc + 16'd1;
    endtask

    task automatic gen_fixed(input logic [7:0] op, input bit st);
        int len;
        len = ref_len(op);
        if (len < 0) begin
            emit(op, st, 1, 0, 2'd1);
        end else begin
            emit(op, st, 1, len == 0, 2'd0);
            for (int i = 1; i <= len; i++) emit(8'($urandom), 0, 0, i == len, 2'd0);
        end
    endtask

    task automatic gen_wide(input bit st, input int sel);
        logic [7:0] op;
        emit(8'hC4, st, 1, 0, 2'd0);
        if (sel < 2) begin
            emit(8'h84, 0, 0, 0, 2'd0);
            for (int i = 1; i <= 4; i++) emit(8'($urandom), 0, 0, i == 4, 2'd0);
        end else if (sel < 5) begin
            op = (sel == 2) ? 8'(8'h15 + $urandom_range(0, 4)) :
                 (sel == 3) ? 8'(8'h36 + $urandom_range(0, 4)) : 8'hA9;
            emit(op, 0, 0, 0, 2'd0);
            for (int i = 1; i <= 2; i++) emit(8'($urandom), 0, 0, i == 2, 2'd0);
        end else begin
            emit(8'h60, 0, 0, 0, 2'd1);
        end
    endtask

    // a/b = low/high for tableswitch, a = npairs for lookupswitch
    task automatic gen_switch(input logic [7:0] op, input bit st, input int a, input int b);
`ifdef JVM_SPLIT_SWITCH_EN
        bit          tab, bad, last;
        longint      cnt, body;
        logic [31:0] w[3];
        int          nw;
        tab = (op == 8'hAA);
        emit(op, st, 1, 0, 2'd0);
        while (m_pc[1:0] != 2'd0) emit(8'($urandom), 0, 0, 0, 2'd0);
        w[0] = $urandom;
        w[1] = a;
        w[2] = b;
        nw   = tab ? 3 : 2;
        cnt  = tab ? (longint'(b) - longint'(a) + 1) : longint'(a);
        body = cnt * (tab ? 4 : 8);
        bad  = (tab ? (b < a) : (a < 0)) || (body > ((longint'(1) << CNT_W) - 1));
        for (int k = 0; k < nw; k++) begin
            for (int j = 3; j >= 0; j--) begin
                last = (k == nw - 1) && (j == 0);
                emit(w[k][8*j +: 8], 0, 0, last && !bad && body == 0,
                     (last && bad) ? 2'd2 : 2'd0);
            end
        end
        if (!bad) begin
            for (int i = 1; i <= int'(body); i++) emit(8'($urandom), 0, 0, i == int'(body), 2'd0);
        end
`else
        emit(op, st, 1, 0, 2'd3);
        if (a == b) need_start = need_start;
`endif
    endtask

    task automatic gen_random();
        int         r, lo;
        logic [7:0] op;
        bit         st;
        if (m_err) repeat ($urandom_range(0, 2)) emit(8'($urandom), 0, 0, 0, 2'd0);
        st = m_err || need_start || ($urandom_range(0, 24) == 0);
        need_start = 0;
        r = $urandom_range(0, 99);
        if (r < 6) begin
            gen_wide(st, $urandom_range(0, 5));
        end else if (r < 10) begin
            lo = int'($urandom_range(0, 40)) - 20;
            gen_switch(8'hAA, st, lo, lo + int'($urandom_range(0, 4)) - 1);
        end else if (r < 14) begin
            gen_switch(8'hAB, st, int'($urandom_range(0, 3)) - (($urandom_range(0, 7) == 0) ? 4 : 0), 0);
        end else if (r < 16) begin
            emit(8'($urandom_range(8'hCB, 8'hFD)), st, 1, 0, 2'd1);
        end else if (r < 18) begin
            emit(8'h11, st, 1, 0, 2'd0);
            emit(8'($urandom), 0, 0, 0, 2'd0);
            need_start = 1;
        end else begin
            op = 8'($urandom);
            if (op == 8'hC4 || op == 8'hAA || op == 8'hAB || (op >= 8'hCB && op <= 8'hFD)) op = 8'h60;
            gen_fixed(op, st);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic st);
        int guard;
        if (gaps_en && $urandom_range(0, 3) == 0) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        in_start = st;
        #1;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 200) check("send_timeout", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_start = 1'b0;
    endtask

    task automatic run_stim();
        logic [8:0] s;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            send(s[7:0], s[8]);
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 2000) begin
            @(negedge clk);
            g++;
        end
        check("drain", exp_q.size(), 32'd0);
    endtask

    always @(negedge clk) begin
        logic [28:0] e;
        case (ready_mode)
            1:       out_ready = 1'b1;
            2:       out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
        #1;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else                  e = '1;
            check("out_beat", {3'b0, out_byte, out_sop, out_eop, out_ins_pc, err, err_code}, {3'b0, e});
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] s;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_start = 1'b0;
        in_byte  = '0;
        @(negedge clk);
        check("reset_valid", {31'b0, out_valid}, 32'd0);
        check("reset_in_ready", {31'b0, in_ready}, 32'd0);
        check("reset_tags", {27'b0, out_sop, out_eop, err, err_code}, 32'd0);
        check("reset_data", {8'b0, out_byte, out_ins_pc}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // short stream: bipush 5, istore_1, return
        emit(8'h10, 1, 1, 0, 2'd0);
        emit(8'h05, 0, 0, 1, 2'd0);
        emit(8'h3C, 0, 1, 1, 2'd0);
        emit(8'hB1, 0, 1, 1, 2'd0);
        run_stim();
        drain();

        // wide iinc
        emit(8'hC4, 1, 1, 0, 2'd0);
        emit(8'h84, 0, 0, 0, 2'd0);
        emit(8'h00, 0, 0, 0, 2'd0);
        emit(8'h01, 0, 0, 0, 2'd0);
        emit(8'hFF, 0, 0, 0, 2'd0);
        emit(8'hFF, 0, 0, 1, 2'd0);
        run_stim();
        drain();

        // tableswitch at PC 1, then a nop at PC 24
        emit(8'h00, 1, 1, 1, 2'd0);
        gen_switch(8'hAA, 0, 0, 1);
        emit(8'h00, 0, 1, 1, 2'd0);
        gen_switch(8'hAB, 1, 0, 0);
        emit(8'h00, 1, 1, 1, 2'd0);
        run_stim();
        drain();

        // undefined opcode at PC 5, trailing bytes dropped
        emit(8'h00, 1, 1, 1, 2'd0);
        repeat (4) emit(8'h00, 0, 1, 1, 2'd0);
        emit(8'hCB, 0, 1, 0, 2'd1);
        emit(8'h60, 0, 1, 1, 2'd0);
        emit(8'h10, 0, 1, 0, 2'd0);
        run_stim();
        drain();
        check("err_sticky", {29'b0, err, err_code}, 32'd5);
        emit(8'h00, 1, 1, 1, 2'd0);
        run_stim();
        drain();
        check("err_cleared", {29'b0, err, err_code}, 32'd0);

        // switch boundary cases: overflow, bad bounds, negative npairs
        gen_switch(8'hAA, 1, 0, 20000);
        gen_switch(8'hAA, 1, 32'h8000_0000, 32'h7FFF_FFFF);
        gen_switch(8'hAA, 1, 5, 4);
        gen_switch(8'hAB, 1, 8192, 0);
        gen_switch(8'hAB, 1, -1, 0);
        emit(8'h00, 1, 1, 1, 2'd0);
        run_stim();
        drain();

        // output stall during sipush
        ready_mode = 1;
        emit(8'h11, 0, 1, 0, 2'd0);
        emit(8'h12, 0, 0, 0, 2'd0);
        emit(8'h34, 0, 0, 1, 2'd0);
        ready_mode = 2;
        s = stim_q.pop_front();
        send(s[7:0], s[8]);
        repeat (5) begin
            @(negedge clk);
            #2;
            check("stall_in_ready", {31'b0, in_ready}, 32'd0);
            check("stall_out", {21'b0, out_valid, out_sop, out_eop, out_byte}, {21'b0, 1'b1, 1'b1, 1'b0, 8'h11});
        end
        ready_mode = 1;
        run_stim();
        drain();

        // randomized instruction mix with random backpressure and gaps
        ready_mode = 0;
        gaps_en    = 1;
        for (int n = 0; n < 400; n++) gen_random();
        run_stim();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
